// File: rtl/audio_pkg.sv
// Shared constants and types for the audio clocking and
// serializer blocks.
package audio_pkg;

    localparam int CNT_W    = 9;
    localparam int MCLK_BIT = 1;
    localparam int SCK_BIT  = 3;
    localparam int LRCK_BIT = 8;
    localparam int SAMPLE_W = 16;
    localparam int FRAME_W  = 2 * SAMPLE_W;

    localparam logic [CNT_W-1:0] FRAME_LOAD = 9'h1FF;

    typedef logic [CNT_W-1:0]   cnt_t;
    typedef logic [FRAME_W-1:0] frame_t;

endpackage

// File: rtl/audio_clk_gen.sv
// Free-running frame counter producing MCLK/SCK/LRCK and the
// frame-load / bit-shift strobes.
module audio_clk_gen
    import audio_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    output logic mclk_o,
    output logic sck_o,
    output logic lrck_o,
    output logic load_stb_o,
    output logic shift_stb_o
);

    cnt_t cnt_q;
    cnt_t cnt_d;

    assign cnt_d = cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Clocks are raw register bits so they cannot glitch.
    assign mclk_o = cnt_q[MCLK_BIT];
    assign sck_o  = cnt_q[SCK_BIT];
    assign lrck_o = cnt_q[LRCK_BIT];

    assign load_stb_o  = (cnt_q == FRAME_LOAD);
    assign shift_stb_o = (cnt_q[3:0] == 4'hF) && !load_stb_o;

endmodule

// File: rtl/speaker_control.sv
// Serializes left/right samples to an external DAC in
// left-justified or I2S framing.
module speaker_control
    import audio_pkg::*;
#(
    parameter int unsigned I2S_MODE = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    output logic                audio_mclk,
    output logic                audio_lrck,
    output logic                audio_sck,
    output logic                audio_sdin,
    output logic                sample_req
);

    logic   load_stb;
    logic   shift_stb;
    frame_t shreg_q;
    frame_t shreg_d;
    logic   dly_q;
    logic   req_q;

    audio_clk_gen u_clk_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .mclk_o      (audio_mclk),
        .sck_o       (audio_sck),
        .lrck_o      (audio_lrck),
        .load_stb_o  (load_stb),
        .shift_stb_o (shift_stb)
    );

    always_comb begin
        shreg_d = shreg_q;
        if (load_stb) begin
            shreg_d = {audio_left, audio_right};
        end else if (shift_stb) begin
            shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q <= '0;
            dly_q   <= 1'b0;
            req_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            req_q   <= load_stb;
            // I2S: hold the outgoing MSB for one extra SCK period.
            if (load_stb || shift_stb) begin
                dly_q <= shreg_q[FRAME_W-1];
            end
        end
    end

    assign audio_sdin = (I2S_MODE != 0) ? dly_q : shreg_q[FRAME_W-1];
    assign sample_req = req_q;

endmodule

// File: tb/tb_speaker_control.sv
// Directed bench: one left-justified and one I2S instance share
// stimulus; frames are captured on SCK rising edges.
module tb_speaker_control;

    logic        clk;
    logic        rst_n;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        mclk0, lrck0, sck0, sdin0, req0;
    logic        mclk1, lrck1, sck1, sdin1, req1;
    logic [8:0]  bcnt;
    int          tests;
    int          fails;

    speaker_control #(.I2S_MODE(0)) dut0 (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .audio_mclk  (mclk0),
        .audio_lrck  (lrck0),
        .audio_sck   (sck0),
        .audio_sdin  (sdin0),
        .sample_req  (req0)
    );

    speaker_control #(.I2S_MODE(1)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .audio_left  (audio_left),
        .audio_right (audio_right),
        .audio_mclk  (mclk1),
        .audio_lrck  (lrck1),
        .audio_sck   (sck1),
        .audio_sdin  (sdin1),
        .sample_req  (req1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side frame position: clk edges since reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcnt <= '0;
        else        bcnt <= bcnt + 9'd1;
    end

    task automatic sync_to(input logic [8:0] pos);
        bit found;
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(posedge clk);
            #1;
            if (bcnt == pos) found = 1'b1;
        end
        tests++;
        if (!found) begin
            fails++;
            $display("FAIL sync_to: position %h not reached, at %h", pos, bcnt);
        end
    endtask

    task automatic capture(input bit sync, input bit chg,
                           input logic [15:0] nl,
                           output logic [31:0] w0,
                           output logic [31:0] w1);
        if (sync) sync_to(9'h000);
        for (int i = 0; i < 32; i++) begin
            if (i == 0) begin
                repeat (8) @(posedge clk);
            end else if (chg && i == 8) begin
                repeat (8) @(posedge clk);
                #1 audio_left = nl;
                repeat (8) @(posedge clk);
            end else begin
                repeat (16) @(posedge clk);
            end
            #1;
            w0[31-i] = sdin0;
            w1[31-i] = sdin1;
            tests++;
            if (sck0 !== 1'b1 || lrck0 !== (i >= 16)) begin
                fails++;
                $display("FAIL bit_clock[%0d]: sck=%b lrck=%b, need sck=1 lrck=%b",
                         i, sck0, lrck0, (i >= 16));
            end
        end
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        audio_left  = 16'hC000;
        audio_right = 16'h0FFF;
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if ({mclk0, lrck0, sck0, sdin0, req0} !== 5'b0) begin
            fails++;
            $display("FAIL reset_out0: got %b need 00000",
                     {mclk0, lrck0, sck0, sdin0, req0});
        end
        tests++;
        if ({mclk1, lrck1, sck1, sdin1, req1} !== 5'b0) begin
            fails++;
            $display("FAIL reset_out1: got %b need 00000",
                     {mclk1, lrck1, sck1, sdin1, req1});
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 513; e++) begin
            @(posedge clk);
            #1;
            if (e == 1 || e == 2) begin
                tests++;
                if (mclk0 !== (e == 2)) begin
                    fails++;
                    $display("FAIL mclk_start e%0d: got %b need %b", e, mclk0, (e == 2));
                end
            end
            if (e == 7 || e == 8) begin
                tests++;
                if (sck0 !== (e == 8)) begin
                    fails++;
                    $display("FAIL sck_start e%0d: got %b need %b", e, sck0, (e == 8));
                end
            end
            if (e == 255 || e == 256) begin
                tests++;
                if (lrck0 !== (e == 256)) begin
                    fails++;
                    $display("FAIL lrck_start e%0d: got %b need %b", e, lrck0, (e == 256));
                end
            end
            tests++;
            if (req0 !== (e == 512)) begin
                fails++;
                $display("FAIL req_start e%0d: got %b need %b", e, req0, (e == 512));
            end
            if (e <= 511) begin
                tests++;
                if (sdin0 !== 1'b0 || sdin1 !== 1'b0) begin
                    fails++;
                    $display("FAIL first_frame_zero e%0d: got %b%b need 00", e, sdin0, sdin1);
                end
            end
        end
    endtask

    task automatic test_left_justified;
        logic [31:0] w0, w1;
        capture(1'b1, 1'b0, 16'h0, w0, w1);
        tests++;
        if (w0 !== 32'hC0000FFF) begin
            fails++;
            $display("FAIL lj_frame: got %h need C0000FFF", w0);
        end
    endtask

    task automatic test_i2s;
        logic [31:0] w0, w1;
        capture(1'b1, 1'b0, 16'h0, w0, w1);
        tests++;
        if (w1 !== 32'hE00007FF) begin
            fails++;
            $display("FAIL i2s_frame: got %h need E00007FF", w1);
        end
    endtask

    task automatic test_mid_frame_change;
        logic [31:0] w0, w1;
        capture(1'b1, 1'b1, 16'h1234, w0, w1);
        tests++;
        if (w0 !== 32'hC0000FFF || w1 !== 32'hE00007FF) begin
            fails++;
            $display("FAIL mid_change_cur: got %h/%h need C0000FFF/E00007FF", w0, w1);
        end
        capture(1'b1, 1'b0, 16'h0, w0, w1);
        tests++;
        if (w0 !== 32'h12340FFF || w1 !== 32'h891A07FF) begin
            fails++;
            $display("FAIL mid_change_next: got %h/%h need 12340FFF/891A07FF", w0, w1);
        end
    endtask

    task automatic test_sample_req_spacing;
        int   pulses;
        logic prev_lrck;
        pulses = 0;
        sync_to(9'h000);
        prev_lrck = lrck0;
        for (int c = 0; c < 5120; c++) begin
            @(posedge clk);
            #1;
            tests++;
            if (req0 !== (bcnt == 9'h000) || req1 !== req0) begin
                fails++;
                $display("FAIL req_align c%0d: got %b/%b need %b", c, req0, req1, (bcnt == 9'h000));
            end
            if (req0 === 1'b1) begin
                pulses++;
                tests++;
                if (lrck0 !== 1'b0 || prev_lrck !== 1'b1) begin
                    fails++;
                    $display("FAIL req_lrck_fall c%0d: lrck %b->%b need 1->0", c, prev_lrck, lrck0);
                end
            end
            prev_lrck = lrck0;
        end
        tests++;
        if (pulses != 10) begin
            fails++;
            $display("FAIL req_count: got %0d need 10", pulses);
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] w0, w1;
        sync_to(9'h150);
        tests++;
        if (lrck0 !== 1'b1 || sdin0 !== 1'b1) begin
            fails++;
            $display("FAIL pre_reset: lrck=%b sdin=%b need 1 1", lrck0, sdin0);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({mclk0, lrck0, sck0, sdin0, req0, mclk1, lrck1, sck1, sdin1, req1} !== 10'b0) begin
            fails++;
            $display("FAIL mid_reset_out: got %b need 0000000000",
                     {mclk0, lrck0, sck0, sdin0, req0, mclk1, lrck1, sck1, sdin1, req1});
        end
        audio_left  = 16'hA5A5;
        audio_right = 16'h5A5A;
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if ({lrck0, sdin0, lrck1, sdin1} !== 4'b0) begin
            fails++;
            $display("FAIL mid_reset_hold: got %b need 0000", {lrck0, sdin0, lrck1, sdin1});
        end
        rst_n = 1'b1;
        capture(1'b0, 1'b0, 16'h0, w0, w1);
        tests++;
        if (w0 !== 32'h0 || w1 !== 32'h0) begin
            fails++;
            $display("FAIL post_reset_first: got %h/%h need 0/0", w0, w1);
        end
        capture(1'b1, 1'b0, 16'h0, w0, w1);
        tests++;
        if (w0 !== 32'hA5A55A5A || w1 !== 32'h52D2AD2D) begin
            fails++;
            $display("FAIL post_reset_second: got %h/%h need A5A55A5A/52D2AD2D", w0, w1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_left_justified();
        test_i2s();
        test_mid_frame_change();
        test_sample_req_spacing();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
